// File: rtl/vending_machine_gen.sv
// Multi-item vending controller: coin credit, one-hot item select, greedy change return.
// Define VM_STOCK_EN to build per-item stock counters (sold_out, restock); otherwise stock is infinite.
module vending_machine_gen #(
  parameter int                         NUM_ITEMS  = 4,
  parameter int                         CREDIT_W   = 7,
  parameter int                         MAX_CREDIT = 100,
  parameter int                         PRICE_W    = 7,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES   = {7'd75, 7'd60, 7'd30, 7'd20},
  parameter int                         STOCK_W    = 4,
  parameter int                         INIT_STOCK = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 insert_coin_5,
  input  logic                 insert_coin_10,
  input  logic                 insert_coin_50,
  input  logic                 cancel,
  input  logic [NUM_ITEMS-1:0] select,
  input  logic                 restock,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] avail,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 dispense,
  output logic [2:0]           dispense_item,
  output logic                 change_5,
  output logic                 change_10,
  output logic                 change_50,
  output logic                 coin_reject,
  output logic [1:0]           state
);

  // Arithmetic width with headroom for credit plus a full 65-unit coin sum.
  localparam int EW = CREDIT_W + 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t               state_q, state_nxt;
  logic [EW-1:0]        credit_x, coin_sum, sel_price;
  logic [2:0]           sel_idx, item_nxt;
  logic                 sel_valid, any_coin;
  logic [CREDIT_W-1:0]  credit_nxt;
  logic [NUM_ITEMS-1:0] stock_dec, sold_out_nxt, avail_nxt;
  logic                 disp_nxt, c5_nxt, c10_nxt, c50_nxt, rej_nxt;

  function automatic logic [EW-1:0] price_of(input int i);
    return EW'(PRICES[i*PRICE_W +: PRICE_W]);
  endfunction

  assign credit_x = EW'(credit);
  assign any_coin = insert_coin_5 | insert_coin_10 | insert_coin_50;
  assign state    = state_q;

  always_comb begin
    coin_sum = '0;
    if (insert_coin_5)  coin_sum = coin_sum + EW'(5);
    if (insert_coin_10) coin_sum = coin_sum + EW'(10);
    if (insert_coin_50) coin_sum = coin_sum + EW'(50);
  end

  always_comb begin
    sel_idx   = '0;
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (select[i]) begin
        sel_idx   = 3'(i);
        sel_price = price_of(i);
      end
    end
  end

  // avail is registered from the current credit, so it is the pre-update view.
  assign sel_valid = $onehot(select) && |(select & avail);

  always_comb begin
    state_nxt  = state_q;
    credit_nxt = credit;
    disp_nxt   = 1'b0;
    item_nxt   = '0;
    c5_nxt     = 1'b0;
    c10_nxt    = 1'b0;
    c50_nxt    = 1'b0;
    rej_nxt    = 1'b0;
    stock_dec  = '0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel) begin
          rej_nxt = any_coin;
          if (state_q == S_COLLECT) state_nxt = S_CHANGE;
        end else if (sel_valid) begin
          rej_nxt    = any_coin;
          state_nxt  = S_DISPENSE;
          disp_nxt   = 1'b1;
          item_nxt   = sel_idx;
          credit_nxt = CREDIT_W'(credit_x - sel_price);
          stock_dec  = select;
        end else if (any_coin) begin
          if (credit_x + coin_sum > EW'(MAX_CREDIT)) begin
            rej_nxt = 1'b1;
          end else begin
            credit_nxt = CREDIT_W'(credit_x + coin_sum);
            state_nxt  = S_COLLECT;
          end
        end
      end
      S_DISPENSE: begin
        rej_nxt   = any_coin;
        state_nxt = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      default: begin
        rej_nxt = any_coin;
        if (credit_x >= EW'(50)) begin
          c50_nxt    = 1'b1;
          credit_nxt = CREDIT_W'(credit_x - EW'(50));
        end else if (credit_x >= EW'(10)) begin
          c10_nxt    = 1'b1;
          credit_nxt = CREDIT_W'(credit_x - EW'(10));
        end else if (credit_x >= EW'(5)) begin
          c5_nxt     = 1'b1;
          credit_nxt = CREDIT_W'(credit_x - EW'(5));
        end else begin
          credit_nxt = '0;
          state_nxt  = S_IDLE;
        end
      end
    endcase
  end

`ifdef VM_STOCK_EN
  logic [STOCK_W-1:0] stock_q   [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_nxt [NUM_ITEMS];

  // Restock overrides a same-cycle purchase decrement.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_nxt[i] = stock_q[i];
      if (restock)
        stock_nxt[i] = STOCK_W'(INIT_STOCK);
      else if (stock_dec[i] && stock_q[i] != '0)
        stock_nxt[i] = stock_q[i] - STOCK_W'(1);
      sold_out_nxt[i] = (stock_nxt[i] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_nxt[i];
    end
  end
`else
  logic unused_stock_cfg;
  assign unused_stock_cfg = ^{restock, stock_dec, STOCK_W[0], INIT_STOCK[0]};
  assign sold_out_nxt     = '0;
`endif

  always_comb begin
    avail_nxt = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      avail_nxt[i] = (EW'(credit_nxt) >= price_of(i)) && !sold_out_nxt[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit        <= '0;
      avail         <= '0;
      sold_out      <= '0;
      dispense      <= 1'b0;
      dispense_item <= '0;
      change_5      <= 1'b0;
      change_10     <= 1'b0;
      change_50     <= 1'b0;
      coin_reject   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      credit        <= credit_nxt;
      avail         <= avail_nxt;
      sold_out      <= sold_out_nxt;
      dispense      <= disp_nxt;
      dispense_item <= item_nxt;
      change_5      <= c5_nxt;
      change_10     <= c10_nxt;
      change_50     <= c50_nxt;
      coin_reject   <= rej_nxt;
    end
  end

endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed self-checking bench for vending_machine_gen (default parameters, INIT_STOCK=1).
module tb_vending_machine_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       insert_coin_5 = 1'b0, insert_coin_10 = 1'b0, insert_coin_50 = 1'b0;
  logic       cancel = 1'b0, restock = 1'b0;
  logic [3:0] select = 4'b0;
  logic [6:0] credit;
  logic [3:0] avail, sold_out;
  logic       dispense, change_5, change_10, change_50, coin_reject;
  logic [2:0] dispense_item;
  logic [1:0] state;

  int tests  = 0;
  int failed = 0;

`ifdef VM_STOCK_EN
  localparam logic [3:0] SO_AFTER_BUY0 = 4'b0001;
`else
  localparam logic [3:0] SO_AFTER_BUY0 = 4'b0000;
`endif

  always #5 clk = ~clk;

  vending_machine_gen #(.INIT_STOCK(1)) dut (
    .clk(clk), .rst(rst),
    .insert_coin_5(insert_coin_5), .insert_coin_10(insert_coin_10), .insert_coin_50(insert_coin_50),
    .cancel(cancel), .select(select), .restock(restock),
    .credit(credit), .avail(avail), .sold_out(sold_out),
    .dispense(dispense), .dispense_item(dispense_item),
    .change_5(change_5), .change_10(change_10), .change_50(change_50),
    .coin_reject(coin_reject), .state(state)
  );

  // Pulse exclusivity holds on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if ((int'(change_5) + int'(change_10) + int'(change_50) > 1) ||
          (dispense && (change_5 || change_10 || change_50))) begin
        failed++;
        $display("FAIL pulse_excl: got disp=%b c50/c10/c5=%b%b%b, want at most one pulse", dispense, change_50, change_10, change_5);
      end
    end
  end

  task automatic clear_in();
    insert_coin_5 = 1'b0; insert_coin_10 = 1'b0; insert_coin_50 = 1'b0;
    cancel = 1'b0; restock = 1'b0; select = 4'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_coins(input logic a5, input logic a10, input logic a50);
    insert_coin_5 = a5; insert_coin_10 = a10; insert_coin_50 = a50;
    step();
    clear_in();
  endtask

  task automatic pulse_select(input logic [3:0] s);
    select = s;
    step();
    clear_in();
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    step();
    clear_in();
  endtask

  task automatic pulse_restock();
    restock = 1'b1;
    step();
    clear_in();
  endtask

  task automatic drain(output int returned);
    returned = 0;
    for (int k = 0; k < 12 && state != 2'd0; k++) begin
      step();
      returned += (change_50 ? 50 : 0) + (change_10 ? 10 : 0) + (change_5 ? 5 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (credit !== 7'd0) begin failed++; $display("FAIL rst_credit: got %0d want 0", credit); end
    tests++; if (state !== 2'd0) begin failed++; $display("FAIL rst_state: got %0d want 0", state); end
    tests++; if ({dispense, change_50, change_10, change_5, coin_reject, avail, sold_out} !== 13'd0) begin
      failed++; $display("FAIL rst_outputs: got %b want all zero", {dispense, change_50, change_10, change_5, coin_reject, avail, sold_out}); end
    rst = 1'b0;
  endtask

  task automatic test_exact_buy();
    pulse_coins(0, 1, 0);
    tests++; if (credit !== 7'd10 || state !== 2'd1) begin failed++; $display("FAIL t1_coin1: got credit=%0d state=%0d want 10/1", credit, state); end
    pulse_coins(0, 1, 0);
    tests++; if (credit !== 7'd20) begin failed++; $display("FAIL t1_coin2: got %0d want 20", credit); end
    tests++; if (avail !== 4'b0001) begin failed++; $display("FAIL t1_avail: got %b want 0001", avail); end
    pulse_select(4'b0001);
    tests++; if (dispense !== 1'b1 || dispense_item !== 3'd0) begin failed++; $display("FAIL t1_dispense: got %b item %0d want 1 item 0", dispense, dispense_item); end
    tests++; if (credit !== 7'd0 || state !== 2'd2) begin failed++; $display("FAIL t1_disp_state: got credit=%0d state=%0d want 0/2", credit, state); end
    insert_coin_10 = 1'b1;
    step();
    clear_in();
    tests++; if (coin_reject !== 1'b1 || credit !== 7'd0) begin failed++; $display("FAIL t1_coin_in_disp: got rej=%b credit=%0d want 1/0", coin_reject, credit); end
    tests++; if (state !== 2'd0 || dispense !== 1'b0 || {change_50, change_10, change_5} !== 3'b000) begin
      failed++; $display("FAIL t1_idle: got state=%0d disp=%b chg=%b want 0/0/000", state, dispense, {change_50, change_10, change_5}); end
  endtask

  task automatic test_overflow_change();
    logic [2:0] exp_seq [3];
    logic [6:0] exp_cr  [3];
    exp_seq = '{3'b010, 3'b010, 3'b001};
    exp_cr  = '{7'd15, 7'd5, 7'd0};
    pulse_restock();
    pulse_coins(0, 0, 1);
    pulse_coins(0, 0, 1);
    tests++; if (credit !== 7'd100) begin failed++; $display("FAIL t2_credit100: got %0d want 100", credit); end
    pulse_coins(1, 0, 0);
    tests++; if (coin_reject !== 1'b1 || credit !== 7'd100) begin failed++; $display("FAIL t2_overflow: got rej=%b credit=%0d want 1/100", coin_reject, credit); end
    tests++; if (avail !== 4'b1111) begin failed++; $display("FAIL t2_avail: got %b want 1111", avail); end
    pulse_select(4'b1000);
    tests++; if (dispense !== 1'b1 || dispense_item !== 3'd3 || credit !== 7'd25) begin
      failed++; $display("FAIL t2_dispense: got disp=%b item=%0d credit=%0d want 1/3/25", dispense, dispense_item, credit); end
    step();
    tests++; if (state !== 2'd3 || {change_50, change_10, change_5} !== 3'b000) begin
      failed++; $display("FAIL t2_enter_change: got state=%0d chg=%b want 3/000", state, {change_50, change_10, change_5}); end
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if ({change_50, change_10, change_5} !== exp_seq[k] || credit !== exp_cr[k]) begin
        failed++; $display("FAIL t2_change%0d: got chg=%b credit=%0d want %b/%0d", k, {change_50, change_10, change_5}, credit, exp_seq[k], exp_cr[k]); end
    end
    step();
    tests++; if (state !== 2'd0) begin failed++; $display("FAIL t2_idle: got %0d want 0", state); end
  endtask

  task automatic test_invalid_select_cancel();
    repeat (3) pulse_coins(0, 1, 0);
    pulse_select(4'b0100);
    tests++; if (dispense !== 1'b0 || credit !== 7'd30 || state !== 2'd1) begin
      failed++; $display("FAIL t3_unaffordable: got disp=%b credit=%0d state=%0d want 0/30/1", dispense, credit, state); end
    pulse_select(4'b0011);
    tests++; if (dispense !== 1'b0 || credit !== 7'd30) begin failed++; $display("FAIL t3_multihot: got disp=%b credit=%0d want 0/30", dispense, credit); end
    pulse_cancel();
    tests++; if (state !== 2'd3 || credit !== 7'd30) begin failed++; $display("FAIL t3_cancel: got state=%0d credit=%0d want 3/30", state, credit); end
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if ({change_50, change_10, change_5} !== 3'b010 || credit !== 7'(20 - 10 * k)) begin
        failed++; $display("FAIL t3_change%0d: got chg=%b credit=%0d want 010/%0d", k, {change_50, change_10, change_5}, credit, 20 - 10 * k); end
    end
    step();
    tests++; if (state !== 2'd0) begin failed++; $display("FAIL t3_idle: got %0d want 0", state); end
  endtask

  task automatic test_cancel_with_coin();
    logic [2:0] exp_seq [3];
    exp_seq = '{3'b100, 3'b010, 3'b001};
    pulse_coins(0, 0, 1);
    pulse_coins(0, 1, 0);
    pulse_coins(1, 0, 0);
    tests++; if (credit !== 7'd65) begin failed++; $display("FAIL t4_credit: got %0d want 65", credit); end
    cancel = 1'b1; insert_coin_10 = 1'b1;
    step();
    clear_in();
    tests++; if (coin_reject !== 1'b1 || state !== 2'd3 || credit !== 7'd65) begin
      failed++; $display("FAIL t4_cancel_coin: got rej=%b state=%0d credit=%0d want 1/3/65", coin_reject, state, credit); end
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if ({change_50, change_10, change_5} !== exp_seq[k]) begin
        failed++; $display("FAIL t4_change%0d: got %b want %b", k, {change_50, change_10, change_5}, exp_seq[k]); end
    end
    step();
    tests++; if (state !== 2'd0 || credit !== 7'd0) begin failed++; $display("FAIL t4_idle: got state=%0d credit=%0d want 0/0", state, credit); end
  endtask

  task automatic test_multi_coin();
    int ret;
    pulse_coins(1, 1, 0);
    tests++; if (credit !== 7'd15) begin failed++; $display("FAIL t_multi_15: got %0d want 15", credit); end
    pulse_coins(1, 1, 1);
    tests++; if (credit !== 7'd80) begin failed++; $display("FAIL t_multi_80: got %0d want 80", credit); end
    pulse_coins(1, 1, 0);
    pulse_coins(1, 0, 0);
    tests++; if (credit !== 7'd100 || coin_reject !== 1'b0) begin failed++; $display("FAIL t_multi_max: got credit=%0d rej=%b want 100/0", credit, coin_reject); end
    pulse_cancel();
    drain(ret);
    tests++; if (ret != 100 || state !== 2'd0 || credit !== 7'd0) begin
      failed++; $display("FAIL t_multi_refund: got ret=%0d state=%0d credit=%0d want 100/0/0", ret, state, credit); end
  endtask

  task automatic test_stock();
    int ret;
    pulse_restock();
    pulse_coins(0, 1, 0);
    pulse_coins(0, 1, 0);
    pulse_select(4'b0001);
    tests++; if (dispense !== 1'b1) begin failed++; $display("FAIL t5_buy1: got %b want 1", dispense); end
    tests++; if (sold_out !== SO_AFTER_BUY0) begin failed++; $display("FAIL t5_soldout: got %b want %b", sold_out, SO_AFTER_BUY0); end
    step();
    pulse_coins(0, 1, 0);
    pulse_coins(0, 1, 0);
`ifdef VM_STOCK_EN
    tests++; if (avail !== 4'b0000) begin failed++; $display("FAIL t5_avail_gated: got %b want 0000", avail); end
    pulse_select(4'b0001);
    tests++; if (dispense !== 1'b0 || credit !== 7'd20 || state !== 2'd1) begin
      failed++; $display("FAIL t5_buy2_ignored: got disp=%b credit=%0d state=%0d want 0/20/1", dispense, credit, state); end
    pulse_restock();
    tests++; if (sold_out !== 4'b0000 || avail !== 4'b0001) begin
      failed++; $display("FAIL t5_restock: got so=%b avail=%b want 0000/0001", sold_out, avail); end
    pulse_cancel();
    drain(ret);
    tests++; if (ret != 20 || state !== 2'd0) begin failed++; $display("FAIL t5_refund: got ret=%0d state=%0d want 20/0", ret, state); end
`else
    tests++; if (avail !== 4'b0001) begin failed++; $display("FAIL t5_avail: got %b want 0001", avail); end
    pulse_select(4'b0001);
    tests++; if (dispense !== 1'b1 || credit !== 7'd0) begin failed++; $display("FAIL t5_buy2: got disp=%b credit=%0d want 1/0", dispense, credit); end
    step();
    pulse_restock();
    tests++; if (sold_out !== 4'b0000 || state !== 2'd0) begin failed++; $display("FAIL t5_restock: got so=%b state=%0d want 0000/0", sold_out, state); end
    ret = 0;
`endif
  endtask

  task automatic test_reset_mid_change();
    pulse_restock();
    pulse_coins(0, 1, 0);
    pulse_coins(0, 1, 0);
    pulse_select(4'b0001);
    step();
    tests++; if (sold_out !== SO_AFTER_BUY0) begin failed++; $display("FAIL t6_soldout: got %b want %b", sold_out, SO_AFTER_BUY0); end
    repeat (4) pulse_coins(0, 1, 0);
    pulse_coins(1, 0, 0);
    tests++; if (credit !== 7'd45) begin failed++; $display("FAIL t6_credit: got %0d want 45", credit); end
    pulse_cancel();
    step();
    tests++; if (change_10 !== 1'b1 || credit !== 7'd35) begin failed++; $display("FAIL t6_first_coin: got c10=%b credit=%0d want 1/35", change_10, credit); end
    #2 rst = 1'b1;
    #1;
    tests++; if (credit !== 7'd0 || state !== 2'd0) begin failed++; $display("FAIL t6_async: got credit=%0d state=%0d want 0/0", credit, state); end
    @(posedge clk);
    #1;
    tests++; if ({dispense, change_50, change_10, change_5, coin_reject, sold_out} !== 9'd0 || credit !== 7'd0) begin
      failed++; $display("FAIL t6_in_reset: got %b credit=%0d want zeros/0", {dispense, change_50, change_10, change_5, coin_reject, sold_out}, credit); end
    rst = 1'b0;
    step();
    step();
    tests++; if (state !== 2'd0 || credit !== 7'd0 || {change_50, change_10, change_5} !== 3'b000 || sold_out !== 4'b0000) begin
      failed++; $display("FAIL t6_after: got state=%0d credit=%0d chg=%b so=%b want 0/0/000/0000", state, credit, {change_50, change_10, change_5}, sold_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exact_buy();
    test_overflow_change();
    test_invalid_select_cancel();
    test_cancel_with_coin();
    test_multi_coin();
    test_stock();
    test_reset_mid_change();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
